// File: rtl/shared_register_arbiter.sv
// Shared WIDTH-bit register written by two four-phase req/ack writers under round-robin arbitration.
// Optional macro SHARED_REG_ACK_TIMEOUT_EN adds a forced release when an owner holds req too long.
module shared_register_arbiter #(
  parameter int unsigned       WIDTH          = 8,
  parameter logic [WIDTH-1:0]  PRESET_VALUE   = {WIDTH{1'b0}},
  parameter int unsigned       TIMEOUT_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             busy,
  output logic             owner,
  output logic             timeout
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SERVE = 1'b1} state_t;

  // TIMEOUT_CYCLES below 2 is not a legal configuration; nothing is elaborated for it.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_below_min
  end

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r, q_s, q_n_r;
  logic             ack_a_r, ack_a_s, ack_b_r, ack_b_s;
  logic             busy_r, busy_s, owner_r, owner_s, timeout_r, timeout_s;
  logic             elig_a_s, elig_b_s, owner_req_s;

`ifdef SHARED_REG_ACK_TIMEOUT_EN
  localparam int unsigned     CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic             blk_a_r, blk_a_s, blk_b_r, blk_b_s;
`endif

  // Next-state and next-output decode for the IDLE/SERVE handshake machine.
  always_comb begin
    state_s   = state_r;
    q_s       = q_r;
    ack_a_s   = ack_a_r;
    ack_b_s   = ack_b_r;
    busy_s    = busy_r;
    owner_s   = owner_r;
    timeout_s = 1'b0;
`ifdef SHARED_REG_ACK_TIMEOUT_EN
    // A block flag survives only while its requester keeps req high.
    blk_a_s   = blk_a_r & req_a;
    blk_b_s   = blk_b_r & req_b;
    cnt_s     = cnt_r;
    if (cnt_r != CNT_TO) begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_inc_s = cnt_r;
    end
    elig_a_s  = req_a & ~blk_a_r;
    elig_b_s  = req_b & ~blk_b_r;
`else
    elig_a_s  = req_a;
    elig_b_s  = req_b;
`endif
    owner_req_s = owner_r ? req_b : req_a;

    case (state_r)
      ST_IDLE: begin
        // On a tie the requester that is not the last owner wins.
        if (elig_a_s && (!elig_b_s || owner_r)) begin
          q_s     = data_a;
          ack_a_s = 1'b1;
          owner_s = 1'b0;
          busy_s  = 1'b1;
          state_s = ST_SERVE;
`ifdef SHARED_REG_ACK_TIMEOUT_EN
          cnt_s   = {CNT_W{1'b0}};
`endif
        end else if (elig_b_s) begin
          q_s     = data_b;
          ack_b_s = 1'b1;
          owner_s = 1'b1;
          busy_s  = 1'b1;
          state_s = ST_SERVE;
`ifdef SHARED_REG_ACK_TIMEOUT_EN
          cnt_s   = {CNT_W{1'b0}};
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (!owner_req_s) begin
          ack_a_s = 1'b0;
          ack_b_s = 1'b0;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
`ifdef SHARED_REG_ACK_TIMEOUT_EN
        end else if (cnt_inc_s == CNT_TO) begin
          ack_a_s   = 1'b0;
          ack_b_s   = 1'b0;
          busy_s    = 1'b0;
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
          cnt_s     = cnt_inc_s;
          if (owner_r) begin
            blk_b_s = 1'b1;
          end else begin
            blk_a_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_inc_s;
`else
        end else begin
          state_s = ST_SERVE;
`endif
        end
      end
      default: begin
        ack_a_s = 1'b0;
        ack_b_s = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; q_n is loaded alongside q so the pair never disagrees.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      q_r       <= PRESET_VALUE;
      q_n_r     <= ~PRESET_VALUE;
      ack_a_r   <= 1'b0;
      ack_b_r   <= 1'b0;
      busy_r    <= 1'b0;
      owner_r   <= 1'b1;
      timeout_r <= 1'b0;
`ifdef SHARED_REG_ACK_TIMEOUT_EN
      cnt_r     <= {CNT_W{1'b0}};
      blk_a_r   <= 1'b0;
      blk_b_r   <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      q_r       <= q_s;
      q_n_r     <= ~q_s;
      ack_a_r   <= ack_a_s;
      ack_b_r   <= ack_b_s;
      busy_r    <= busy_s;
      owner_r   <= owner_s;
      timeout_r <= timeout_s;
`ifdef SHARED_REG_ACK_TIMEOUT_EN
      cnt_r     <= cnt_s;
      blk_a_r   <= blk_a_s;
      blk_b_r   <= blk_b_s;
`endif
    end
  end

  assign q       = q_r;
  assign q_n     = q_n_r;
  assign ack_a   = ack_a_r;
  assign ack_b   = ack_b_r;
  assign busy    = busy_r;
  assign owner   = owner_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_shared_register_arbiter.sv
// Self-checking bench for shared_register_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_shared_register_arbiter;

  localparam logic [7:0] PRE = 8'h5A;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       ack_a, ack_b, busy, owner, timeout;
  logic [7:0] q, q_n;

  int n_cmp = 0;
  int n_err = 0;

  shared_register_arbiter #(
    .WIDTH(8), .PRESET_VALUE(PRE), .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .q(q), .q_n(q_n),
    .busy(busy), .owner(owner), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    tick();
    reset = 1'b0;
    n_cmp++; if (q !== PRE) begin n_err++; $display("FAIL reset_q: got %h expected %h", q, PRE); end
    n_cmp++; if (q_n !== ~PRE) begin n_err++; $display("FAIL reset_q_n: got %h expected %h", q_n, ~PRE); end
    n_cmp++; if ({ack_a, ack_b, busy, owner, timeout} !== 5'b00010) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 00010", {ack_a, ack_b, busy, owner, timeout});
    end
  endtask

  task automatic test_single_write();
    req_a = 1'b1; data_a = 8'h3C;
    tick();
    n_cmp++; if (q !== 8'h3C || q_n !== 8'hC3) begin
      n_err++; $display("FAIL single_q: got %h/%h expected 3c/c3", q, q_n);
    end
    n_cmp++; if ({ack_a, ack_b, busy, owner} !== 4'b1010) begin
      n_err++; $display("FAIL single_grant: got %b expected 1010", {ack_a, ack_b, busy, owner});
    end
    req_a = 1'b0;
    tick();
    n_cmp++; if ({ack_a, busy, q} !== {2'b00, 8'h3C}) begin
      n_err++; $display("FAIL single_release: got %b %b %h expected 0 0 3c", ack_a, busy, q);
    end
  endtask

  task automatic test_tie();
    reset = 1'b1; tick(); reset = 1'b0;
    req_a = 1'b1; data_a = 8'h11; req_b = 1'b1; data_b = 8'h22;
    tick();
    n_cmp++; if ({ack_a, ack_b, owner, q} !== {3'b100, 8'h11}) begin
      n_err++; $display("FAIL tie_first: got %b%b%b %h expected 100 11", ack_a, ack_b, owner, q);
    end
    req_a = 1'b0;
    tick();
    n_cmp++; if ({ack_a, ack_b, busy} !== 3'b000) begin
      n_err++; $display("FAIL tie_gap: got %b expected 000", {ack_a, ack_b, busy});
    end
    tick();
    n_cmp++; if ({ack_a, ack_b, owner, q} !== {3'b011, 8'h22}) begin
      n_err++; $display("FAIL tie_second: got %b%b%b %h expected 011 22", ack_a, ack_b, owner, q);
    end
    req_b = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic       w;
    logic [7:0] da, db, exp_q;
    w = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    da = 8'($urandom); db = 8'($urandom); data_a = da; data_b = db;
    for (int g = 0; g < 6; g++) begin
      tick();
      exp_q = w ? db : da;
      n_cmp++; if ({ack_a, ack_b} !== (w ? 2'b01 : 2'b10) || owner !== w || q !== exp_q) begin
        n_err++; $display("FAIL b2b_grant%0d: got ack %b%b owner %b q %h expected winner %b q %h",
                          g, ack_a, ack_b, owner, q, w, exp_q);
      end
      if (w) req_b = 1'b0; else req_a = 1'b0;
      tick();
      n_cmp++; if ({ack_a, ack_b} !== 2'b00) begin
        n_err++; $display("FAIL b2b_release%0d: got %b%b expected 00", g, ack_a, ack_b);
      end
      if (w) begin db = 8'($urandom); data_b = db; req_b = 1'b1; end
      else   begin da = 8'($urandom); data_a = da; req_a = 1'b1; end
      w = ~w;
    end
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_serve();
    req_b = 1'b1; data_b = 8'hE1;
    tick();
    chk("rms_grant", {7'd0, ack_b}, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({ack_a, ack_b, busy, owner, q, q_n} !== {4'b0001, PRE, ~PRE}) begin
      n_err++; $display("FAIL rms_abort: got %b%b%b%b %h %h expected 0001 %h %h",
                        ack_a, ack_b, busy, owner, q, q_n, PRE, ~PRE);
    end
    data_b = 8'h77;
    tick();
    n_cmp++; if ({ack_b, busy, q} !== {2'b11, 8'h77}) begin
      n_err++; $display("FAIL rms_regrant: got %b%b %h expected 11 77", ack_b, busy, q);
    end
    req_b = 1'b0;
    tick();
  endtask

  // Transaction-level model: who holds the register, who was served last, and what was written.
  task automatic test_random();
    int         holder;          // -1 = nobody, 0 = A, 1 = B
    int         last;
    logic [7:0] val;
    logic       rq[2];
    logic [7:0] dt[2];
    int         hold[2];
    logic [1:0] exp_ack;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    tick();
    reset = 1'b0;
    holder = -1; last = 1; val = PRE;
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      rq[0] = req_a; rq[1] = req_b; dt[0] = data_a; dt[1] = data_b;
      if (reset) begin
        holder = -1; last = 1; val = PRE;
      end else if (holder < 0) begin
        if (rq[0] && rq[1]) holder = 1 - last;
        else if (rq[0])     holder = 0;
        else if (rq[1])     holder = 1;
        else                holder = -1;
        if (holder >= 0) begin
          last = holder;
          val  = dt[holder];
        end
      end else if (!rq[holder]) begin
        holder = -1;
      end
      tick();
      exp_ack = (holder == 0) ? 2'b10 : (holder == 1) ? 2'b01 : 2'b00;
      n_cmp++;
      if ({ack_a, ack_b} !== exp_ack || busy !== (holder >= 0) || owner !== last[0] ||
          q !== val || q_n !== ~val || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL rand_c%0d: got ack %b%b busy %b owner %b q %h q_n %h to %b expected ack %b busy %b owner %b q %h",
                 c, ack_a, ack_b, busy, owner, q, q_n, timeout, exp_ack, holder >= 0, last[0], val);
      end
      // Next stimulus: owners release within two cycles, waiters toggle freely.
      reset = ($urandom_range(63) == 0);
      for (int i = 0; i < 2; i++) begin
        if (holder == i) begin
          if (hold[i] >= 1 || $urandom_range(1) == 1) rq[i] = 1'b0;
          else hold[i]++;
        end else begin
          hold[i] = 0;
          rq[i] = ($urandom_range(2) != 0);
          dt[i] = 8'($urandom);
        end
      end
      req_a = rq[0]; req_b = rq[1]; data_a = dt[0]; data_b = dt[1];
    end
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
  endtask

`ifdef SHARED_REG_ACK_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    reset = 1'b1; tick(); reset = 1'b0;
    req_a = 1'b1; data_a = 8'h0F; req_b = 1'b1; data_b = 8'hF0;
    tick();
    chk("to_grant_a", {6'd0, ack_a, ack_b}, 8'h02);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (timeout) seen = 1'b1;
    end
    n_cmp++; if (!seen || ack_a !== 1'b0) begin
      n_err++; $display("FAIL to_pulse: got seen %b ack_a %b expected 1 0", seen, ack_a);
    end
    tick();
    n_cmp++; if ({timeout, ack_a, ack_b, q} !== {3'b001, 8'hF0}) begin
      n_err++; $display("FAIL to_b_next: got %b%b%b %h expected 001 f0", timeout, ack_a, ack_b, q);
    end
    req_b = 1'b0;
    tick(); tick(); tick();
    chk("to_a_blocked", {7'd0, ack_a}, 8'h00);
    req_a = 1'b0; tick();
    req_a = 1'b1; tick();
    chk("to_a_again", {7'd0, ack_a}, 8'h01);
    req_a = 1'b0; tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_back_to_back();
    test_reset_mid_serve();
`ifdef SHARED_REG_ACK_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
